// File: rtl/classifier_pkg.sv
// Shared types and constants for the classifier scheduler slice.
package classifier_pkg;
    localparam int CLASS_W    = 3;
    localparam int NUM_FEAT   = 5;
    localparam int FEAT_W_DEF = 33;

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, ABORT} sched_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction
endpackage

// File: rtl/classifier_scheduler_if.sv
// Requester-side and classifier-side bus of the scheduler; slave = scheduler.
interface classifier_scheduler_if import classifier_pkg::*; #(
    parameter int NUM_REQ = 4,
    parameter int FEAT_W  = FEAT_W_DEF
);
    logic [NUM_REQ-1:0]                 req;
    logic [NUM_REQ-1:0]                 req_method;
    logic [NUM_REQ*NUM_FEAT*FEAT_W-1:0] req_feat;
    logic [NUM_REQ-1:0]                 ack;
    logic [NUM_REQ-1:0]                 done;
    logic [CLASS_W-1:0]                 done_class;
    logic                               done_timeout;
    logic [7:0]                         timeout_cnt;
    logic                               dm_rst;
    logic                               dm_start;
    logic                               dm_method;
    logic [FEAT_W-1:0]                  dm_in1, dm_in2, dm_in3, dm_in4, dm_in5;
    logic                               dm_busy;
    logic                               dm_valid;
    logic [CLASS_W-1:0]                 dm_class;

    modport slave (
        input  req, req_method, req_feat, dm_busy, dm_valid, dm_class,
        output ack, done, done_class, done_timeout, timeout_cnt,
               dm_rst, dm_start, dm_method, dm_in1, dm_in2, dm_in3, dm_in4, dm_in5
    );
    modport master (
        output req, req_method, req_feat, dm_busy, dm_valid, dm_class,
        input  ack, done, done_class, done_timeout, timeout_cnt,
               dm_rst, dm_start, dm_method, dm_in1, dm_in2, dm_in3, dm_in4, dm_in5
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request after i_ptr, wrapping.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_grant_idx,
    output logic          o_any
);
    logic [IW-1:0] w_k;

    // Scan from farthest to nearest so the nearest requester overwrites.
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_any       = 1'b0;
        w_k         = '0;
        for (int i = N; i >= 1; i--) begin
            w_k = IW'((int'(i_ptr) + i) % N);
            if (i_req[w_k]) begin
                o_grant      = '0;
                o_grant[w_k] = 1'b1;
                o_grant_idx  = w_k;
                o_any        = 1'b1;
            end
        end
    end
endmodule

// File: rtl/classifier_scheduler.sv
// Shares one decision_making classifier among NUM_REQ requesters with RR arbitration and a run timeout.
module classifier_scheduler import classifier_pkg::*; #(
    parameter int NUM_REQ        = 4,
    parameter int FEAT_W         = FEAT_W_DEF,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                   clk,
    input  logic                   rst,
    classifier_scheduler_if.slave  bus
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);

    sched_state_t       r_state, w_next;
    logic [ID_W-1:0]    r_ptr, r_owner, w_idx;
    logic [NUM_REQ-1:0] w_grant;
    logic               w_any, w_go, w_expire;
    logic [TMR_W-1:0]   r_timer;
    logic [FEAT_W-1:0]  r_feat [NUM_FEAT];
    logic               r_method;
    logic [NUM_REQ-1:0] r_ack, r_done;
    logic [CLASS_W-1:0] r_done_class;
    logic               r_done_to;
    logic [7:0]         r_tcnt;

    rr_arbiter #(.N(NUM_REQ), .IW(ID_W)) u_arb (
        .i_req       (bus.req),
        .i_ptr       (r_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_idx),
        .o_any       (w_any)
    );

    assign w_go     = (r_state == IDLE) && w_any && !bus.dm_busy;
    assign w_expire = (r_timer == TMR_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_go) w_next = LAUNCH;
            LAUNCH:  w_next = WAIT;
            WAIT: begin
                // A valid landing on the expiry cycle beats the abort.
                if (bus.dm_valid)  w_next = IDLE;
                else if (w_expire) w_next = ABORT;
            end
            ABORT:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr        <= ID_W'(NUM_REQ - 1);
            r_owner      <= '0;
            r_timer      <= '0;
            r_method     <= 1'b0;
            r_ack        <= '0;
            r_done       <= '0;
            r_done_class <= '0;
            r_done_to    <= 1'b0;
            r_tcnt       <= '0;
            for (int k = 0; k < NUM_FEAT; k++) r_feat[k] <= '0;
        end else begin
            r_ack        <= '0;
            r_done       <= '0;
            r_done_class <= '0;
            r_done_to    <= 1'b0;
            case (r_state)
                IDLE: if (w_go) begin
                    r_ptr    <= w_idx;
                    r_owner  <= w_idx;
                    r_method <= bus.req_method[w_idx];
                    r_ack    <= w_grant;
                    for (int k = 0; k < NUM_FEAT; k++)
                        r_feat[k] <= bus.req_feat[(int'(w_idx) * NUM_FEAT + k) * FEAT_W +: FEAT_W];
                end
                LAUNCH: r_timer <= '0;
                WAIT: begin
                    r_timer <= r_timer + 1'b1;
                    if (bus.dm_valid) begin
                        r_done[r_owner] <= 1'b1;
                        r_done_class    <= bus.dm_class;
                    end else if (w_expire) begin
                        // Timed-out result is reported during the ABORT cycle itself.
                        r_done[r_owner] <= 1'b1;
                        r_done_to       <= 1'b1;
                        r_tcnt          <= sat_inc8(r_tcnt);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ack          = r_ack;
    assign bus.done         = r_done;
    assign bus.done_class   = r_done_class;
    assign bus.done_timeout = r_done_to;
    assign bus.timeout_cnt  = r_tcnt;
    assign bus.dm_rst       = rst | (r_state == ABORT);
    assign bus.dm_start     = (r_state == LAUNCH);
    assign bus.dm_method    = r_method;
    assign bus.dm_in1       = r_feat[0];
    assign bus.dm_in2       = r_feat[1];
    assign bus.dm_in3       = r_feat[2];
    assign bus.dm_in4       = r_feat[3];
    assign bus.dm_in5       = r_feat[4];
endmodule

// File: tb/tb_classifier_scheduler.sv
// Bench for classifier_scheduler: table of single runs, then stall, reset-mid-run and fairness sequences.
module tb_classifier_scheduler;
    localparam int NR = 4;
    localparam int FW = 33;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    classifier_scheduler_if #(.NUM_REQ(NR), .FEAT_W(FW)) bus ();

    classifier_scheduler #(.NUM_REQ(NR), .FEAT_W(FW), .TIMEOUT_CYCLES(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [NR-1:0] owner;
        logic [2:0]    cls;
        logic          to;
    } exp_t;

    typedef struct {
        logic [NR-1:0] req;
        logic [NR-1:0] meth;
        int            lat;
        int            win;
        bit            to;
    } row_t;

    exp_t sb[$];
    row_t rows[9];

    int n_chk = 0, n_pass = 0;
    int cyc = 0, ack_cyc = -1, start_cyc = -1, rst_cyc = -1, done_cyc = -1;
    int n_rst = 0, n_done = 0, exp_tcnt = 0;
    bit onehot_bad = 0;
    int m_lat = 1, m_cnt = 0;
    bit m_act = 0, m_busy = 0, force_busy = 0;
    logic [2:0] m_cls = '0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    endtask

    function automatic logic [FW-1:0] feat(input int i, input int k, input int row);
        return {k[0], 8'(row), 4'(i), 4'(k), 13'd0, 3'(row + i + k)};
    endfunction

    task automatic set_feats(input int row);
        for (int i = 0; i < NR; i++)
            for (int k = 0; k < 5; k++)
                bus.req_feat[(i * 5 + k) * FW +: FW] = feat(i, k, row);
    endtask

    function automatic bit feat_ok(input int w, input int row);
        return bus.dm_in1 === feat(w, 0, row) && bus.dm_in2 === feat(w, 1, row) &&
               bus.dm_in3 === feat(w, 2, row) && bus.dm_in4 === feat(w, 3, row) &&
               bus.dm_in5 === feat(w, 4, row);
    endfunction

    // One clock: monitor/scoreboard on this cycle's outputs, then advance the classifier model.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if ($countones(bus.ack) > 1 || $countones(bus.done) > 1) onehot_bad = 1;
        if (bus.ack != '0) ack_cyc = cyc;
        if (bus.dm_start) start_cyc = cyc;
        if (bus.dm_rst && !rst) begin rst_cyc = cyc; n_rst++; end
        if (bus.done != '0) begin
            done_cyc = cyc;
            n_done++;
            if (sb.size() == 0) chk("done_unexpected", 64'(bus.done), 0);
            else begin
                e = sb.pop_front();
                chk("done_owner", 64'(bus.done), 64'(e.owner));
                chk("done_class", 64'(bus.done_class), 64'(e.cls));
                chk("done_timeout", 64'(bus.done_timeout), 64'(e.to));
            end
        end
        bus.dm_valid = 1'b0;
        bus.dm_class = 3'($urandom_range(7));
        if (bus.dm_rst) begin
            m_act = 0; m_busy = 0;
        end else if (bus.dm_start) begin
            m_act = 1; m_busy = 1; m_cnt = 0; m_cls = bus.dm_in1[2:0];
        end else if (m_act) begin
            m_cnt++;
            if (m_cnt == m_lat) begin
                bus.dm_valid = 1'b1; bus.dm_class = m_cls; m_act = 0; m_busy = 0;
            end
        end
        bus.dm_busy = m_busy | force_busy;
    endtask

    task automatic wait_ack(input int maxc);
        ack_cyc = -1;
        for (int n = 0; n < maxc && ack_cyc < 0; n++) step();
    endtask

    task automatic wait_sb(input int maxc);
        for (int n = 0; n < maxc && sb.size() != 0; n++) step();
        if (sb.size() != 0) begin
            chk("done_wait_bound", 64'(sb.size()), 0);
            sb.delete();
        end
    endtask

    initial begin
        int w, x, saved;
        rows[0] = '{4'b0100, 4'b0100, 5,  2, 0};
        rows[1] = '{4'b0011, 4'b0001, 1,  0, 0};
        rows[2] = '{4'b0011, 4'b0000, 2,  1, 0};
        rows[3] = '{4'b1001, 4'b1000, 7,  3, 0};
        rows[4] = '{4'b1000, 4'b0000, 1,  3, 0};
        rows[5] = '{4'b0110, 4'b0010, 1000, 1, 1};
        rows[6] = '{4'b0110, 4'b0110, 16, 2, 0};
        rows[7] = '{4'b1111, 4'b0101, 15, 3, 0};
        rows[8] = '{4'b0001, 4'b0001, 17, 0, 1};

        bus.req = '0; bus.req_method = '0; bus.req_feat = '0;
        bus.dm_busy = 1'b0; bus.dm_valid = 1'b0; bus.dm_class = '0;
        repeat (3) step();
        chk("rst_dm_rst", 64'(bus.dm_rst), 1);
        rst = 1'b0;
        step();
        chk("rst_ack_done", 64'({bus.ack, bus.done}), 0);
        chk("rst_start_dmrst", 64'({bus.dm_start, bus.dm_rst}), 0);
        chk("rst_tcnt", 64'(bus.timeout_cnt), 0);
        chk("rst_latches", 64'({bus.dm_method, bus.dm_in1}), 0);

        for (int r = 0; r < 9; r++) begin
            m_lat = rows[r].lat;
            set_feats(r);
            bus.req_method = rows[r].meth;
            bus.req = rows[r].req;
            n_rst = 0;
            wait_ack(8);
            w = rows[r].win;
            chk("row_ack", 64'(bus.ack), 64'(1 << w));
            chk("row_start", 64'(bus.dm_start), 1);
            chk("row_feat_method", 64'(feat_ok(w, r) && bus.dm_method == rows[r].meth[w]), 1);
            sb.push_back('{NR'(1 << w), rows[r].to ? 3'd0 : 3'(r + w), rows[r].to});
            bus.req = '0;
            wait_sb(60);
            if (rows[r].to) begin
                exp_tcnt++;
                chk("to_dm_rst_lat", 64'(rst_cyc - start_cyc), TO + 1);
                chk("to_done_cycle", 64'(done_cyc), 64'(rst_cyc));
            end else begin
                chk("done_lat", 64'(done_cyc - start_cyc), 64'(rows[r].lat + 1));
            end
            chk("dm_rst_pulses", 64'(n_rst), 64'(rows[r].to));
            chk("timeout_cnt", 64'(bus.timeout_cnt), 64'(exp_tcnt));
            step();
        end

        // Stall: classifier busy keeps IDLE from granting.
        m_lat = 3;
        set_feats(30);
        force_busy = 1; bus.dm_busy = 1'b1;
        bus.req = 4'b0010;
        ack_cyc = -1;
        repeat (6) step();
        chk("stall_no_ack", 64'(ack_cyc < 0), 1);
        force_busy = 0; bus.dm_busy = 1'b0;
        x = cyc;
        wait_ack(8);
        chk("stall_ack_lat", 64'(ack_cyc - x), 1);
        chk("stall_ack", 64'(bus.ack), 64'(4'b0010));
        sb.push_back('{4'b0010, 3'(30 + 1), 1'b0});
        bus.req = '0;
        wait_sb(30);

        // Reset during WAIT: run abandoned, no done, pointer back to its reset value.
        m_lat = 1000;
        set_feats(40);
        bus.req = 4'b1000;
        wait_ack(8);
        chk("midrst_ack", 64'(bus.ack), 64'(4'b1000));
        bus.req = '0;
        repeat (3) step();
        rst = 1'b1;
        step();
        chk("midrst_dm_rst", 64'(bus.dm_rst), 1);
        rst = 1'b0;
        saved = n_done;
        exp_tcnt = 0;
        repeat (20) step();
        chk("midrst_no_done", 64'(n_done - saved), 0);
        chk("midrst_outputs", 64'({bus.ack, bus.done, bus.dm_start, bus.dm_method, bus.timeout_cnt}), 0);
        chk("midrst_feat", 64'(bus.dm_in1), 0);

        // Fairness: all four held, each re-asserts after its own done.
        m_lat = 2;
        set_feats(50);
        bus.req_method = 4'b1010;
        bus.req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            w = n % NR;
            wait_ack(8);
            chk("fair_ack", 64'(bus.ack), 64'(1 << w));
            chk("fair_feat", 64'(feat_ok(w, 50) && bus.dm_method == bus.req_method[w]), 1);
            sb.push_back('{NR'(1 << w), 3'(50 + w), 1'b0});
            bus.req[w] = 1'b0;
            wait_sb(30);
            bus.req[w] = 1'b1;
        end
        bus.req = '0;
        repeat (4) step();
        chk("onehot_ack_done", 64'(onehot_bad), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
